// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives the PLL reset, retries on lock timeout and releases
// the core reset only after the synchronized lock has been stable long enough.
module pll_lock_sequencer #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRY     = 4,
   parameter int CNT_W         = 20
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       restart,
   output logic       pll_rst,
   output logic       core_rst,
   output logic       ready,
   output logic       fail,
   output logic [3:0] retry_cnt,
   output logic [7:0] relock_cnt
);
   localparam logic [2:0] S_RESET  = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_STABLE = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_FAIL   = 3'd4;
   localparam logic [CNT_W-1:0] RST_END = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_END  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] ST_END  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [3:0]       MAX_R   = 4'(MAX_RETRY);

   logic [1:0]       sync_q;
   logic             locked_s;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       retry_q, retry_d;
   logic [7:0]       relock_q, relock_d;
   logic             pll_rst_q, core_rst_q, ready_q, fail_q;

   assign locked_s   = sync_q[1];
   assign pll_rst    = pll_rst_q;
   assign core_rst   = core_rst_q;
   assign ready      = ready_q;
   assign fail       = fail_q;
   assign retry_cnt  = retry_q;
   assign relock_cnt = relock_q;

   // restart overrides every state, so a simultaneous lock loss is never counted
   always_comb begin
      state_d  = state_q;
      retry_d  = retry_q;
      relock_d = relock_q;
      if (restart) begin
         state_d = S_RESET;
         retry_d = '0;
      end else begin
         case (state_q)
            S_RESET: state_d = (cnt_q == RST_END) ? S_WAIT : S_RESET;
            S_WAIT: begin
               if (locked_s) begin
                  state_d = S_STABLE;
               end else if (cnt_q == TO_END) begin
                  retry_d = retry_q + 4'd1;
                  state_d = (retry_d == MAX_R) ? S_FAIL : S_RESET;
               end
            end
            S_STABLE: begin
               if (!locked_s) begin
                  state_d = S_WAIT;
               end else if (cnt_q == ST_END) begin
                  state_d = S_RUN;
                  retry_d = '0;
               end
            end
            S_RUN: begin
               if (!locked_s) begin
                  state_d  = S_RESET;
                  relock_d = (relock_q == 8'hff) ? relock_q : relock_q + 8'd1;
               end
            end
            S_FAIL: state_d = S_FAIL;
            default: state_d = S_RESET;
         endcase
      end
      cnt_d = (restart || state_d != state_q || state_q == S_RUN || state_q == S_FAIL) ? '0 : cnt_q + CNT_ONE;
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         state_q    <= S_RESET;
         cnt_q      <= '0;
         retry_q    <= '0;
         relock_q   <= '0;
         pll_rst_q  <= 1'b1;
         core_rst_q <= 1'b1;
         ready_q    <= 1'b0;
         fail_q     <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], pll_locked};
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         retry_q    <= retry_d;
         relock_q   <= relock_d;
         pll_rst_q  <= (state_d == S_RESET) || (state_d == S_FAIL);
         core_rst_q <= (state_d != S_RUN);
         ready_q    <= (state_d == S_RUN);
         fail_q     <= (state_d == S_FAIL);
      end
   end
endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Reset and lock sequencer for the core PLL. It runs on the PLL reference clock and drives the PLL's active-high reset input. It watches the asynchronous lock output, retries with a bounded timeout, and releases the downstream core reset only after lock has been stable for a programmable time. It sits between the board reset and the clock wrapper, and is the single source of core reset for every PLL output domain; each domain resynchronizes `core_rst` locally.

## Interface
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per reset attempt (≥2).
- `LOCK_TIMEOUT`, 50000: cycles to wait for lock after `pll_rst` release, 1 ms at 50 MHz (≥2).
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release (≥1).
- `MAX_RETRY`, 4: lock timeouts tolerated before entering FAIL (1..15).
- `CNT_W`, 20: shared counter width; must hold max(`RST_CYCLES`, `LOCK_TIMEOUT`, `STABLE_CYCLES`).
- `refclk` in 1: the single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL lock output, asynchronous to `refclk`.
- `restart` in 1: synchronous single-cycle request to resequence the PLL.
- `pll_rst` out 1: active-high reset to the PLL.
- `core_rst` out 1: active-high downstream core reset.
- `ready` out 1: high while in RUN.
- `fail` out 1: high while in FAIL.
- `retry_cnt` out 4: lock timeouts in the current sequence.
- `relock_cnt` out 8: lock losses seen in RUN; saturates at 255.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to produce `locked_s`; the decision logic uses only `locked_s`.
- All outputs are registered. Outputs are a Moore function of state, except the counters, which are plain registers.
- One shared counter `cnt` is cleared on every state entry and increments in each state that uses it.
- States and outputs (`pll_rst`/`core_rst`/`ready`/`fail`):
  - RESET_PLL: 1/1/0/0.
  - WAIT_LOCK: 0/1/0/0.
  - STABLE: 0/1/0/0.
  - RUN: 0/0/1/0.
  - FAIL: 1/1/0/1 (the PLL is held in reset).
- Transitions:
  - RESET_PLL: after `cnt` = `RST_CYCLES`-1, go to WAIT_LOCK.
  - WAIT_LOCK, `locked_s`=1: go to STABLE.
  - WAIT_LOCK timeout (`cnt` = `LOCK_TIMEOUT`-1 with `locked_s`=0): increment `retry_cnt`. If the new value equals `MAX_RETRY`, go to FAIL; otherwise go to RESET_PLL.
  - STABLE, `locked_s`=0: go to WAIT_LOCK. `retry_cnt` is unchanged and the timeout restarts.
  - STABLE, `cnt` = `STABLE_CYCLES`-1 with `locked_s`=1: go to RUN and clear `retry_cnt`.
  - RUN, `locked_s`=0: go to RESET_PLL and increment `relock_cnt`, saturating at 255.
  - FAIL: leaves only via `restart` or `rst_n`.
- `restart`=1 has highest priority in any state, including FAIL:
  - go to RESET_PLL with `cnt`=0, `retry_cnt`=0 and `fail` clearing;
  - `relock_cnt` is not incremented, even if the FSM was in RUN;
  - `restart` and a lock loss in the same cycle count as a restart only.
- If a timeout and `locked_s` rising occur in the same cycle, the lock wins and the FSM goes to STABLE.

## Timing
- Reset values while `rst_n`=0:
  - state RESET_PLL, `cnt`=0;
  - `pll_rst`=1, `core_rst`=1, `ready`=0, `fail`=0;
  - `retry_cnt`=0, `relock_cnt`=0, synchronizer flops 0.
- Asserting `rst_n` mid-operation forces all of the above immediately, without waiting for a clock edge.
- Let edge 1 be the first `refclk` rising edge after `rst_n` deasserts.
- `pll_rst` is high for exactly `RST_CYCLES` cycles per attempt. It falls at edge `RST_CYCLES`.
- With `pll_locked` held at 1 from reset:
  - `locked_s`=1 from edge 2;
  - WAIT_LOCK is entered at edge `RST_CYCLES`, STABLE at edge `RST_CYCLES`+1;
  - `core_rst` falls and `ready` rises together at edge `RST_CYCLES`+1+`STABLE_CYCLES`.
- Lock loss in RUN: `core_rst` rises and `ready` falls at the 3rd edge after `pll_locked` falls (2 synchronizer edges plus 1 state edge).
- `restart` sampled at edge k: `pll_rst`=1 and `core_rst`=1 from edge k.
- `core_rst` never deasserts unless `locked_s` has been 1 for `STABLE_CYCLES` consecutive cycles immediately before.

## Test plan
All scenarios use `RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=8, `MAX_RETRY`=3.
- **Clean lock.** `pll_locked`=1 from reset → `pll_rst` high at edges 1–3, low from edge 4. `core_rst` falls and `ready` rises at edge 13. `retry_cnt`=0.
- **Glitch in STABLE.** `pll_locked` low for 1 cycle, 5 cycles into STABLE → return to WAIT_LOCK, then STABLE again. `core_rst` stays high for at least 8 more `locked_s` cycles. `retry_cnt`=0.
- **Timeout to FAIL.** `pll_locked`=0 throughout → three `pll_rst` pulses of 4 cycles, each followed by 20 WAIT_LOCK cycles. Then `fail`=1, `retry_cnt`=3, `pll_rst` held at 1.
- **Restart recovery.** From FAIL, pulse `restart` with `pll_locked`=1 → `fail`=0 and `retry_cnt`=0 at the same edge. `ready`=1 exactly 4+1+8 edges later.
- **Lock loss in RUN.** Drop `pll_locked` in RUN → `core_rst`=1 at the 3rd edge and `relock_cnt`=1. Repeat 260 times → `relock_cnt` stays at 255.
- **Async reset and collision.** Assert `rst_n` mid-STABLE → all outputs at reset values before the next edge. Separately, drive `restart` in the same cycle as a lock loss in RUN → RESET_PLL and `relock_cnt` unchanged.
